alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the sequential ALU.
// Also provides the signed-overflow helpers used by the arithmetic ops.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_RSUB = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_ADC  = 4'd7;
    localparam logic [3:0] ALU_SBC  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Overflow from operand and result sign bits: x + y, and x - y.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

    function automatic logic sub_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb != y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; the first bit is
// consumed on the start edge so the product is ready WIDTH edges after start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // Upper half accumulates the multiplicand, lower half holds unused multiplier bits.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand_q <= a;
                product <= step({{WIDTH{1'b0}}, b}, a);
                cnt_q   <= CW'(1);
                run_q   <= 1'b1;
            end else if (run_q) begin
                product <= step(product, mcand_q);
                cnt_q   <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake: single-cycle logic/arith/shift ops and
// a multi-cycle unsigned multiply; result and N/Z/C/V flags hold between operations.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic [3:0]       iALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oALUOut,
    output logic [WIDTH-1:0] oALUOutHi,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    state_t             state_q;
    logic [3:0]         flags_q;
    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     wide;
    logic               c_res;
    logic               v_res;
    logic               cin;
    logic [SHW-1:0]     shamt;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    assign cin       = flags_q[FLAG_C];
    assign shamt     = B[SHW-1:0];
    assign mul_start = iStart && (state_q == ST_IDLE) && (iALUControl == ALU_MUL);

    assign N = flags_q[FLAG_N];
    assign Z = flags_q[FLAG_Z];
    assign C = flags_q[FLAG_C];
    assign V = flags_q[FLAG_V];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (iClock),
        .rst_n   (iReset_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (product)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        wide  = '0;
        res   = '0;
        c_res = 1'b0;
        v_res = 1'b0;
        case (iALUControl)
            ALU_ADD, ALU_ADC: begin
                wide  = {1'b0, A} + {1'b0, B}
                      + ((iALUControl == ALU_ADC) ? {{WIDTH{1'b0}}, cin} : {(WIDTH+1){1'b0}});
                res   = wide[WIDTH-1:0];
                c_res = wide[WIDTH];
                v_res = add_ovf(A[WIDTH-1], B[WIDTH-1], wide[WIDTH-1]);
            end
            ALU_SUB, ALU_SBC: begin
                // Bit WIDTH of the extended difference is the borrow.
                wide  = {1'b0, A} - {1'b0, B}
                      - ((iALUControl == ALU_SBC) ? {{WIDTH{1'b0}}, cin} : {(WIDTH+1){1'b0}});
                res   = wide[WIDTH-1:0];
                c_res = wide[WIDTH];
                v_res = sub_ovf(A[WIDTH-1], B[WIDTH-1], wide[WIDTH-1]);
            end
            ALU_RSUB: begin
                wide  = {1'b0, B} - {1'b0, A};
                res   = wide[WIDTH-1:0];
                c_res = wide[WIDTH];
                v_res = sub_ovf(B[WIDTH-1], A[WIDTH-1], wide[WIDTH-1]);
            end
            ALU_AND: res = A & B;
            ALU_OR:  res = A | B;
            ALU_XOR: res = A ^ B;
            ALU_SHL: begin
                // The extra bit on the shifted-out side catches the last bit lost; 0 for shamt 0.
                wide  = {1'b0, A} << shamt;
                res   = wide[WIDTH-1:0];
                c_res = wide[WIDTH];
            end
            ALU_SHR: begin
                wide  = {A, 1'b0} >> shamt;
                res   = wide[WIDTH:1];
                c_res = wide[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q         <= ST_IDLE;
            oBusy           <= 1'b0;
            oDone           <= 1'b0;
            oALUOut         <= '0;
            oALUOutHi       <= '0;
            flags_q         <= '0;
            flags_q[FLAG_Z] <= 1'b1;
        end else begin
            oDone <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        if (iALUControl == ALU_MUL) begin
                            state_q <= ST_MUL;
                            oBusy   <= 1'b1;
                        end else begin
                            oALUOut         <= res;
                            oALUOutHi       <= '0;
                            flags_q[FLAG_N] <= res[WIDTH-1];
                            flags_q[FLAG_Z] <= (res == '0);
                            flags_q[FLAG_C] <= c_res;
                            flags_q[FLAG_V] <= v_res;
                            oDone           <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // Results stay untouched until the multiplier reports completion.
                    if (mul_done) begin
                        state_q         <= ST_IDLE;
                        oBusy           <= 1'b0;
                        oALUOut         <= product[WIDTH-1:0];
                        oALUOutHi       <= product[2*WIDTH-1:WIDTH];
                        flags_q[FLAG_N] <= product[WIDTH-1];
                        flags_q[FLAG_Z] <= (product == '0);
                        flags_q[FLAG_C] <= |product[2*WIDTH-1:WIDTH];
                        flags_q[FLAG_V] <= 1'b0;
                        oDone           <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int MASK = FULL - 1;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } outs_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         n, z, c, v;

    int    n_checks = 0;
    int    n_errors = 0;
    outs_t last_exp;
    outs_t reset_exp;

    alu_seq #(.WIDTH(W)) dut (
        .iClock      (clk),
        .iReset_n    (rst_n),
        .iStart      (start),
        .iALUControl (op),
        .A           (a),
        .B           (b),
        .oBusy       (busy),
        .oDone       (done),
        .oALUOut     (res),
        .oALUOutHi   (res_hi),
        .N           (n),
        .Z           (z),
        .C           (c),
        .V           (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic outs_t observed();
        return outs_t'{hi: res_hi, lo: res, n: n, z: z, c: c, v: v};
    endfunction

    // Reference model: integer arithmetic straight from the opcode definitions.
    function automatic outs_t model(input int opc, input int x, input int y, input int cin);
        outs_t o;
        int r, hi, cy, sx, sy, sr, s, p;
        bit arith;
        r = 0; hi = 0; cy = 0; sr = 0; arith = 0; p = 0;
        sx = (x >= HALF) ? x - FULL : x;
        sy = (y >= HALF) ? y - FULL : y;
        s  = y % W;
        case (opc)
            0:  begin r = x + y;       cy = (r >= FULL);      sr = sx + sy;       arith = 1; end
            1:  begin r = x - y;       cy = (x < y);          sr = sx - sy;       arith = 1; end
            2:  begin r = y - x;       cy = (y < x);          sr = sy - sx;       arith = 1; end
            3:  r = x & y;
            4:  r = x | y;
            5:  begin r = x << s; cy = (s == 0) ? 0 : (x >> (W - s)) & 1; end
            6:  begin r = x >> s; cy = (s == 0) ? 0 : (x >> (s - 1)) & 1; end
            7:  begin r = x + y + cin; cy = (r >= FULL);      sr = sx + sy + cin; arith = 1; end
            8:  begin r = x - y - cin; cy = (x < y + cin);    sr = sx - sy - cin; arith = 1; end
            9:  r = x ^ y;
            10: begin p = x * y; r = p; hi = p / FULL; cy = (hi != 0); end
            default: r = 0;
        endcase
        r     = r & MASK;
        o.lo  = r[W-1:0];
        o.hi  = hi[W-1:0];
        o.n   = (r >= HALF);
        o.z   = (opc == 10) ? (p == 0) : (r == 0);
        o.c   = cy[0];
        o.v   = arith && (sr < -HALF || sr > HALF - 1);
        return o;
    endfunction

    task automatic do_single(input string tag, input logic [3:0] opc,
                             input logic [W-1:0] x, input logic [W-1:0] y);
        outs_t e;
        @(negedge clk);
        start = 1'b1; op = opc; a = x; b = y;
        e = model(int'(opc), int'(x), int'(y), int'(last_exp.c));
        @(posedge clk); #1;
        check({tag, " done"}, 64'(done), 64'(1));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " outs"}, 64'(observed()), 64'(e));
        last_exp = e;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " done low"}, 64'(done), 64'(0));
        check({tag, " hold"}, 64'(observed()), 64'(last_exp));
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input bit poke);
        outs_t e;
        int    busy_cycles;
        bit    done_seen;
        bit    held_ok;
        busy_cycles = 0; done_seen = 0; held_ok = 1;
        e = model(10, int'(x), int'(y), 0);
        @(negedge clk);
        start = 1'b1; op = 4'd10; a = x; b = y;
        @(posedge clk); #1;
        for (int i = 0; i < 4 * W; i++) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            if (busy) busy_cycles++;
            if (observed() !== last_exp) held_ok = 0;
            @(negedge clk);
            start = poke && (i == 2);
            op    = 4'd0;
            a     = W'($urandom);
            b     = W'($urandom);
            @(posedge clk); #1;
        end
        check({tag, " done seen"}, 64'(done_seen), 64'(1));
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'(W));
        check({tag, " held while busy"}, 64'(held_ok), 64'(1));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        check({tag, " outs"}, 64'(observed()), 64'(e));
        last_exp = e;
    endtask

    initial begin
        reset_exp = '0;
        reset_exp.z = 1'b1;
        last_exp = reset_exp;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 64'(observed()), 64'(reset_exp));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        do_single("add ff+01", 4'd0, 8'hFF, 8'h01);
        do_single("sub 80-01", 4'd1, 8'h80, 8'h01);
        do_single("add set c", 4'd0, 8'hFF, 8'h01);
        do_single("sbc 10-10-1", 4'd8, 8'h10, 8'h10);
        do_single("shl 81<<1", 4'd5, 8'h81, 8'h01);
        do_single("shr 03>>1", 4'd6, 8'h03, 8'h01);
        do_single("shl by 0", 4'd5, 8'hA5, 8'h00);
        do_single("adc 7f+00+0", 4'd7, 8'h7F, 8'h00);
        do_single("rsub 01-80", 4'd2, 8'h80, 8'h01);
        do_single("reserved 13", 4'd13, 8'h55, 8'hAA);
        idle_check("idle after directed");

        run_mul("mul ff*ff", 8'hFF, 8'hFF, 1'b1);
        do_single("add after mul", 4'd0, 8'h12, 8'h34);
        idle_check("idle after mul");
        run_mul("mul zero", 8'h00, 8'h9C, 1'b0);

        // Back-to-back ADDs: one result per cycle, in order.
        for (int i = 0; i < 16; i++)
            do_single($sformatf("b2b add %0d", i), 4'd0, W'($urandom), W'($urandom));
        idle_check("idle after b2b");

        // Random mix including reserved opcodes and occasional multiplies.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 10)
                run_mul($sformatf("rand mul %0d", i), W'($urandom), W'($urandom), 1'b0);
            else
                do_single($sformatf("rand op%0d %0d", r, i), 4'(r), W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) idle_check($sformatf("rand idle %0d", i));
        end

        // Reset in the middle of a multiply aborts it with no completion pulse.
        @(negedge clk);
        start = 1'b1; op = 4'd10; a = 8'hC3; b = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort outs", 64'(observed()), 64'(reset_exp));
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        last_exp = reset_exp;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("no done after abort %0d", i), 64'(done), 64'(0));
        end
        do_single("add 2+3 after abort", 4'd0, 8'h02, 8'h03);
        idle_check("final idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
